rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Write-back and read-port scheduler in front of the two-entry X/Y register file.
- Shares the file's single rw select and its one-hot load strobes (lacc/ldm/lse) between three write requesters (ALU accumulator, memory load, sign-extend immediate) and one read requester.
- Grants one slot per cycle and drives the file's strobe and data inputs from registered outputs.
- Uses aging counters so that memory and immediate writes cannot be starved by the accumulator or by reads.

Parameters:
- DW, 16, data width of all write payloads and register-file data outputs.
- STARVE_LIMIT, 4, cycles a valid ld/se request may wait ungranted before it is promoted; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- acc_valid  in  1  accumulator write request
- acc_dst  in  1  destination register, 0=X, 1=Y
- acc_data  in  DW  accumulator value
- acc_ready  out  1  grant; combinational
- ld_valid  in  1  memory-load write request
- ld_dst  in  1  destination register
- ld_data  in  DW  load value
- ld_ready  out  1  grant; combinational
- se_valid  in  1  sign-extend write request
- se_dst  in  1  destination register
- se_data  in  DW  immediate value
- se_ready  out  1  grant; combinational
- rd_req  in  1  read request
- rd_sel  in  1  register to read, 0=X, 1=Y
- rd_ack  out  1  read grant; combinational
- rd_done  out  1  file output holds the requested register this cycle
- rf_rw  out  1  to file rw
- rf_lacc  out  1  to file lacc
- rf_ldm  out  1  to file ldm
- rf_lse  out  1  to file lse
- rf_acc  out  DW  to file acc
- rf_load  out  DW  to file load
- rf_se  out  DW  to file se

Behaviour:
- Reset (rst high at a clk edge):
  - Registered outputs: rf_* = 0, rd_done = 0.
  - Age counters = 0; pending read-pipeline bit cleared.
  - While rst is high, all ready outputs and rd_ack = 0.
- Handshake:
  - A transfer occurs in a cycle where valid/req and ready/ack are both 1.
  - Requesters hold valid, dst and data (or req and sel) stable until granted.
  - At most one grant per cycle.
- Grant priority, highest first:
  1. ld if ld age = STARVE_LIMIT.
  2. se if se age = STARVE_LIMIT.
  3. rd_req.
  4. acc.
  5. ld.
  6. se.
- Age counters (ld, se):
  - Increment each cycle valid=1 and not granted; saturate at STARVE_LIMIT.
  - Clear on grant or when valid=0.
- Write latency:
  - Grant in cycle N. In cycle N+1, exactly one strobe is 1, rf_rw = granted dst, and the matching rf_* data bus carries the granted data.
  - File updates at the end of N+1; the value is readable from slot N+2.
- Read latency:
  - Ack in cycle N. In cycle N+1, all strobes are 0 and rf_rw = rd_sel.
  - File output captures at the end of N+1; rd_done pulses for exactly one cycle in N+2.
- Idle slot (no grant in N):
  - Strobes 0 in N+1.
  - rf_rw and all data buses hold their previous values.
- A write slot followed by a read slot of the same register returns the new value; the controller never places a read and a write in the same slot.
- Non-selected data buses hold their previous values; only the granted source's bus is loaded.
- Reset mid-operation:
  - A slot already driven in the reset cycle completes.
  - A grant made in the reset cycle is impossible, since ready/ack are 0.
  - A pending rd_done is dropped.
- Back-to-back grants are allowed every cycle; strobes may be high on consecutive cycles.

Decomposition:
- Package rf_ctrl_pkg:
  - DST_X=0, DST_Y=1.
  - Slot-source encoding SRC_NONE, SRC_RD, SRC_ACC, SRC_LD, SRC_SE (3 bits).
  - Age counter width 4.
- Sub-module rf_age_cnt: saturating age counter with valid/grant inputs and a starved output, instantiated for ld and for se.

Test Plan:
- Write then read:
  - acc_valid, dst=X, data=0x0008 -> acc_ready same cycle; next cycle rf_lacc=1, rf_rw=0, rf_acc=0x0008.
  - Then rd_req sel=X -> rd_done two cycles after ack, with file out = 0x0008.
- Simultaneous writers:
  - acc (Y, 0x1000), ld (X, 0x0006), se (X, 0x0009) valid together -> grant order acc, ld, se on three consecutive cycles.
  - Strobes lacc, ldm, lse follow, each one cycle after its grant.
- Starvation:
  - acc_valid held high continuously plus ld_valid -> ld granted in cycle 5 after its valid rose, when age reaches 4.
  - Then acc resumes.
- Read priority:
  - rd_req (Y) and acc_valid asserted together -> rd_ack first, acc_ready the next cycle.
  - Slot sequence: rf_rw=1 with no strobe, then the lacc strobe.
- Reset mid-stream:
  - rst high for 1 cycle right after a rd_ack -> rd_done never pulses.
  - Outputs are 0 the cycle after the reset edge; ready/ack are 0 while rst=1.
- Idle hold:
  - Single se write of 0x00FF to Y, then no requests -> strobes 0.
  - rf_rw stays 1 and rf_se stays 0x00FF.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared encodings for the X/Y register-file write-back and read scheduler.
package rf_ctrl_pkg;

    localparam int unsigned AGE_W = 4;

    localparam logic DST_X = 1'b0;
    localparam logic DST_Y = 1'b1;

    // Which requester owns the next register-file slot.
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_RD   = 3'd1,
        SRC_ACC  = 3'd2,
        SRC_LD   = 3'd3,
        SRC_SE   = 3'd4
    } rf_src_e;

endpackage

// File: rtl/rf_age_cnt.sv
// Saturating wait counter for one write requester; flags when it must be promoted.
module rf_age_cnt
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    input  logic grant_i,
    output logic starved_o
);

    localparam logic [AGE_W-1:0] LIMIT_W = AGE_W'(LIMIT);

    logic [AGE_W-1:0] age_q;
    logic [AGE_W-1:0] age_d;
    logic             starved_q;

    always_comb begin
        age_d = '0;
        if (valid_i && !grant_i) begin
            age_d = (age_q == LIMIT_W) ? age_q : age_q + AGE_W'(1);
        end
    end

    // Starved flag is registered alongside the count so it matches age_q exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_q     <= '0;
            starved_q <= 1'b0;
        end else begin
            age_q     <= age_d;
            starved_q <= (age_d == LIMIT_W);
        end
    end

    assign starved_o = starved_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// One-slot-per-cycle scheduler sharing the X/Y register file between three
// writers and one reader, with aging so ld/se writes cannot be starved.
module rf_wb_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned DW           = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          acc_valid,
    input  logic          acc_dst,
    input  logic [DW-1:0] acc_data,
    output logic          acc_ready,
    input  logic          ld_valid,
    input  logic          ld_dst,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          se_valid,
    input  logic          se_dst,
    input  logic [DW-1:0] se_data,
    output logic          se_ready,
    input  logic          rd_req,
    input  logic          rd_sel,
    output logic          rd_ack,
    output logic          rd_done,
    output logic          rf_rw,
    output logic          rf_lacc,
    output logic          rf_ldm,
    output logic          rf_lse,
    output logic [DW-1:0] rf_acc,
    output logic [DW-1:0] rf_load,
    output logic [DW-1:0] rf_se
);

    rf_src_e       gnt_src;
    logic          ld_starved;
    logic          se_starved;

    logic          rw_q,    rw_d;
    logic          lacc_q,  lacc_d;
    logic          ldm_q,   ldm_d;
    logic          lse_q,   lse_d;
    logic [DW-1:0] acc_q,   acc_d;
    logic [DW-1:0] load_q,  load_d;
    logic [DW-1:0] se_q,    se_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_done_q;

    rf_age_cnt #(.LIMIT(STARVE_LIMIT)) u_ld_age (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (ld_valid),
        .grant_i   (ld_ready),
        .starved_o (ld_starved)
    );

    rf_age_cnt #(.LIMIT(STARVE_LIMIT)) u_se_age (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (se_valid),
        .grant_i   (se_ready),
        .starved_o (se_starved)
    );

    // Fixed priority with starved ld/se promoted above reads and the accumulator.
    always_comb begin
        gnt_src = SRC_NONE;
        if (rst) begin
            gnt_src = SRC_NONE;
        end else if (ld_valid && ld_starved) begin
            gnt_src = SRC_LD;
        end else if (se_valid && se_starved) begin
            gnt_src = SRC_SE;
        end else if (rd_req) begin
            gnt_src = SRC_RD;
        end else if (acc_valid) begin
            gnt_src = SRC_ACC;
        end else if (ld_valid) begin
            gnt_src = SRC_LD;
        end else if (se_valid) begin
            gnt_src = SRC_SE;
        end
    end

    assign acc_ready = (gnt_src == SRC_ACC);
    assign ld_ready  = (gnt_src == SRC_LD);
    assign se_ready  = (gnt_src == SRC_SE);
    assign rd_ack    = (gnt_src == SRC_RD);

    // Next slot: idle slots keep rw and every data bus, only strobes drop.
    always_comb begin
        rw_d      = rw_q;
        lacc_d    = 1'b0;
        ldm_d     = 1'b0;
        lse_d     = 1'b0;
        acc_d     = acc_q;
        load_d    = load_q;
        se_d      = se_q;
        rd_pend_d = 1'b0;
        unique case (gnt_src)
            SRC_RD: begin
                rw_d      = rd_sel;
                rd_pend_d = 1'b1;
            end
            SRC_ACC: begin
                rw_d   = acc_dst;
                lacc_d = 1'b1;
                acc_d  = acc_data;
            end
            SRC_LD: begin
                rw_d   = ld_dst;
                ldm_d  = 1'b1;
                load_d = ld_data;
            end
            SRC_SE: begin
                rw_d  = se_dst;
                lse_d = 1'b1;
                se_d  = se_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rw_q      <= DST_X;
            lacc_q    <= 1'b0;
            ldm_q     <= 1'b0;
            lse_q     <= 1'b0;
            acc_q     <= '0;
            load_q    <= '0;
            se_q      <= '0;
            rd_pend_q <= 1'b0;
            rd_done_q <= 1'b0;
        end else begin
            rw_q      <= rw_d;
            lacc_q    <= lacc_d;
            ldm_q     <= ldm_d;
            lse_q     <= lse_d;
            acc_q     <= acc_d;
            load_q    <= load_d;
            se_q      <= se_d;
            rd_pend_q <= rd_pend_d;
            rd_done_q <= rd_pend_q;
        end
    end

    assign rf_rw   = rw_q;
    assign rf_lacc = lacc_q;
    assign rf_ldm  = ldm_q;
    assign rf_lse  = lse_q;
    assign rf_acc  = acc_q;
    assign rf_load = load_q;
    assign rf_se   = se_q;
    assign rd_done = rd_done_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed requests, a small X/Y file model,
// and a monitor that checks every strobe slot and every rd_done pulse.
module tb_rf_wb_arbiter;
    import rf_ctrl_pkg::*;

    localparam int unsigned DW = 16;
    localparam logic [1:0] K_ACC = 2'd0;
    localparam logic [1:0] K_LD  = 2'd1;
    localparam logic [1:0] K_SE  = 2'd2;
    localparam logic [1:0] K_RD  = 2'd3;

    typedef struct packed {
        logic [1:0]    kind;
        logic          dst;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          acc_valid, acc_dst, acc_ready;
    logic [DW-1:0] acc_data;
    logic          ld_valid, ld_dst, ld_ready;
    logic [DW-1:0] ld_data;
    logic          se_valid, se_dst, se_ready;
    logic [DW-1:0] se_data;
    logic          rd_req, rd_sel, rd_ack, rd_done;
    logic          rf_rw, rf_lacc, rf_ldm, rf_lse;
    logic [DW-1:0] rf_acc, rf_load, rf_se;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rd_done_cnt = 0;
    logic hold_acc = 1'b0;

    exp_t wr_q[$];
    exp_t rd_q[$];
    int   wr_g[$];
    int   rd_ackq[$];
    logic [1:0] glog_k[$];
    int   glog_c[$];

    logic       tr_rw   [0:1023];
    logic [2:0] tr_strb [0:1023];

    // Behavioural X/Y register file driven by the DUT's outputs.
    logic [DW-1:0] fx = '0;
    logic [DW-1:0] fy = '0;
    logic [DW-1:0] fout = '0;

    rf_wb_arbiter #(.DW(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .acc_valid(acc_valid), .acc_dst(acc_dst), .acc_data(acc_data), .acc_ready(acc_ready),
        .ld_valid(ld_valid), .ld_dst(ld_dst), .ld_data(ld_data), .ld_ready(ld_ready),
        .se_valid(se_valid), .se_dst(se_dst), .se_data(se_data), .se_ready(se_ready),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_done(rd_done),
        .rf_rw(rf_rw), .rf_lacc(rf_lacc), .rf_ldm(rf_ldm), .rf_lse(rf_lse),
        .rf_acc(rf_acc), .rf_load(rf_load), .rf_se(rf_se)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rf_lacc) begin
            if (rf_rw) fy <= rf_acc; else fx <= rf_acc;
        end else if (rf_ldm) begin
            if (rf_rw) fy <= rf_load; else fx <= rf_load;
        end else if (rf_lse) begin
            if (rf_rw) fy <= rf_se; else fx <= rf_se;
        end else begin
            fout <= rf_rw ? fy : fx;
        end
    end

    function automatic exp_t mk(logic [1:0] k, logic d, logic [DW-1:0] v);
        exp_t e;
        e.kind = k;
        e.dst  = d;
        e.data = v;
        return e;
    endfunction

    function automatic int gk(int i);
        if (i < glog_k.size()) return int'(glog_k[i]);
        return -1;
    endfunction

    function automatic int gc(int i);
        if (i < glog_c.size()) return glog_c[i];
        return -1;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a write slot or rd_done appears.
    always @(negedge clk) begin
        logic [2:0]    strb;
        logic [1:0]    k;
        logic [DW-1:0] d;
        exp_t          e;
        int            g;
        strb = {rf_lacc, rf_ldm, rf_lse};
        if (cyc < 1024) begin
            tr_rw[cyc]   = rf_rw;
            tr_strb[cyc] = strb;
        end
        chk("one_grant", 64'($countones({acc_ready, ld_ready, se_ready, rd_ack}) <= 1), 64'(1));
        if (strb != 3'b000) begin
            case (strb)
                3'b100:  begin k = K_ACC; d = rf_acc;  end
                3'b010:  begin k = K_LD;  d = rf_load; end
                3'b001:  begin k = K_SE;  d = rf_se;   end
                default: begin k = K_RD;  d = '0;      end
            endcase
            if (wr_q.size() == 0 || wr_g.size() == 0) begin
                chk("wr_unexpected", 64'({k, rf_rw, d}), 64'(0));
            end else begin
                e = wr_q.pop_front();
                g = wr_g.pop_front();
                chk("wr_slot", 64'({k, rf_rw, d}), 64'({e.kind, e.dst, e.data}));
                chk("wr_latency", 64'(cyc - g), 64'(1));
            end
        end
        if (rd_done) begin
            rd_done_cnt++;
            if (rd_q.size() == 0 || rd_ackq.size() == 0) begin
                chk("rd_unexpected", 64'(rd_done), 64'(0));
            end else begin
                e = rd_q.pop_front();
                g = rd_ackq.pop_front();
                chk("rd_data", 64'(fout), 64'(e.data));
                chk("rd_latency", 64'(cyc - g), 64'(2));
            end
        end
    end

    // One cycle: sample grants mid-cycle, retire granted requests after the edge.
    task automatic tick();
        logic ga, gl, gs, gr;
        @(negedge clk);
        ga = acc_valid && acc_ready;
        gl = ld_valid && ld_ready;
        gs = se_valid && se_ready;
        gr = rd_req && rd_ack;
        if (ga) begin glog_k.push_back(K_ACC); glog_c.push_back(cyc); wr_g.push_back(cyc); end
        if (gl) begin glog_k.push_back(K_LD);  glog_c.push_back(cyc); wr_g.push_back(cyc); end
        if (gs) begin glog_k.push_back(K_SE);  glog_c.push_back(cyc); wr_g.push_back(cyc); end
        if (gr) begin glog_k.push_back(K_RD);  glog_c.push_back(cyc); rd_ackq.push_back(cyc); end
        @(posedge clk);
        #1;
        if (ga && !hold_acc) acc_valid = 1'b0;
        if (gl) ld_valid = 1'b0;
        if (gs) se_valid = 1'b0;
        if (gr) rd_req = 1'b0;
    endtask

    task automatic run(int budget);
        int n = 0;
        while ((acc_valid || ld_valid || se_valid || rd_req) && n < budget) begin
            tick();
            n++;
        end
        chk("run_drained", 64'({acc_valid, ld_valid, se_valid, rd_req}), 64'(0));
        acc_valid = 1'b0;
        ld_valid  = 1'b0;
        se_valid  = 1'b0;
        rd_req    = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int s;
        rst = 1'b1;
        acc_valid = 1'b1; acc_dst = DST_X; acc_data = '0;
        ld_valid = 1'b0;  ld_dst = DST_X;  ld_data = '0;
        se_valid = 1'b0;  se_dst = DST_X;  se_data = '0;
        rd_req = 1'b1;    rd_sel = DST_X;

        // Reset: no grants while rst is high, all registered outputs cleared.
        @(negedge clk);
        chk("rst_ready", 64'({acc_ready, ld_ready, se_ready, rd_ack}), 64'(0));
        @(negedge clk);
        chk("rst_state", 64'({rf_rw, rf_lacc, rf_ldm, rf_lse, rd_done, rf_acc, rf_load, rf_se}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0; acc_valid = 1'b0; rd_req = 1'b0;

        // Write X=0x0008 from acc, then read it back.
        glog_k.delete(); glog_c.delete();
        acc_dst = DST_X; acc_data = 16'h0008; acc_valid = 1'b1;
        wr_q.push_back(mk(K_ACC, DST_X, 16'h0008));
        s = cyc;
        run(20);
        chk("t1_acc_grant", 64'({gk(0), gc(0)}), 64'({int'(K_ACC), s}));
        rd_sel = DST_X; rd_req = 1'b1;
        rd_q.push_back(mk(K_RD, DST_X, 16'h0008));
        run(20);
        idle(4);

        // Three writers at once: acc, ld, se on consecutive cycles.
        glog_k.delete(); glog_c.delete();
        acc_dst = DST_Y; acc_data = 16'h1000; acc_valid = 1'b1;
        ld_dst  = DST_X; ld_data  = 16'h0006; ld_valid  = 1'b1;
        se_dst  = DST_X; se_data  = 16'h0009; se_valid  = 1'b1;
        wr_q.push_back(mk(K_ACC, DST_Y, 16'h1000));
        wr_q.push_back(mk(K_LD,  DST_X, 16'h0006));
        wr_q.push_back(mk(K_SE,  DST_X, 16'h0009));
        s = cyc;
        run(20);
        chk("t2_order", 64'({gk(0), gk(1), gk(2)}), 64'({int'(K_ACC), int'(K_LD), int'(K_SE)}));
        chk("t2_cycles", 64'({gc(1) - gc(0), gc(2) - gc(1), gc(0) - s}), 64'({32'd1, 32'd1, 32'd0}));
        idle(3);

        // Continuous acc must not starve ld beyond the age limit.
        glog_k.delete(); glog_c.delete();
        hold_acc = 1'b1;
        acc_dst = DST_X; acc_data = 16'h0001; acc_valid = 1'b1;
        ld_dst  = DST_X; ld_data  = 16'h00AA; ld_valid  = 1'b1;
        repeat (4) wr_q.push_back(mk(K_ACC, DST_X, 16'h0001));
        wr_q.push_back(mk(K_LD, DST_X, 16'h00AA));
        repeat (2) wr_q.push_back(mk(K_ACC, DST_X, 16'h0001));
        s = cyc;
        repeat (7) tick();
        hold_acc = 1'b0; acc_valid = 1'b0;
        chk("t3_acc_first", 64'({gk(0), gk(3), gc(3) - s}), 64'({int'(K_ACC), int'(K_ACC), 32'd3}));
        chk("t3_ld_promoted", 64'({gk(4), gc(4) - s}), 64'({int'(K_LD), 32'd4}));
        chk("t3_acc_resumes", 64'({gk(5), gc(5) - s}), 64'({int'(K_ACC), 32'd5}));
        idle(3);

        // Read beats acc: read slot of Y (no strobe), then the lacc slot.
        glog_k.delete(); glog_c.delete();
        rd_sel = DST_Y; rd_req = 1'b1;
        acc_dst = DST_X; acc_data = 16'h0123; acc_valid = 1'b1;
        rd_q.push_back(mk(K_RD, DST_Y, 16'h1000));
        wr_q.push_back(mk(K_ACC, DST_X, 16'h0123));
        s = cyc;
        run(20);
        idle(4);
        chk("t4_order", 64'({gk(0), gc(0) - s, gk(1), gc(1) - s}), 64'({int'(K_RD), 32'd0, int'(K_ACC), 32'd1}));
        chk("t4_rd_slot", 64'({tr_rw[s + 1], tr_strb[s + 1]}), 64'(4'b1000));
        chk("t4_wr_slot", 64'({tr_rw[s + 2], tr_strb[s + 2]}), 64'(4'b0100));

        // Reset right after an ack drops the pending rd_done.
        glog_k.delete(); glog_c.delete();
        rd_sel = DST_X; rd_req = 1'b1;
        tick();
        chk("t5_ack", 64'(gk(0)), 64'(K_RD));
        rst = 1'b1;
        acc_dst = DST_X; acc_data = 16'h0055; acc_valid = 1'b1;
        @(negedge clk);
        chk("t5_rst_ready", 64'({acc_ready, ld_ready, se_ready, rd_ack}), 64'(0));
        chk("t5_slot_completes", 64'({rf_rw, rf_lacc, rf_ldm, rf_lse}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0; acc_valid = 1'b0;
        rd_ackq.delete();
        @(negedge clk);
        chk("t5_post_rst", 64'({rf_rw, rf_lacc, rf_ldm, rf_lse, rd_done, rf_acc, rf_load, rf_se}), 64'(0));
        idle(3);
        chk("t5_no_rd_done", 64'(rd_done_cnt), 64'(2));

        // Single se write to Y, then idle: strobes low, rw and buses held.
        glog_k.delete(); glog_c.delete();
        se_dst = DST_Y; se_data = 16'h00FF; se_valid = 1'b1;
        wr_q.push_back(mk(K_SE, DST_Y, 16'h00FF));
        run(20);
        idle(4);
        s = gc(0);
        for (int i = 2; i <= 4; i++) begin
            chk("t6_idle_slot", 64'({tr_rw[s + i], tr_strb[s + i]}), 64'(4'b1000));
        end
        chk("t6_hold", 64'({rf_rw, rf_se, rf_acc, rf_load}), 64'({1'b1, 16'h00FF, 16'h0000, 16'h0000}));
        chk("t6_file_y", 64'(fy), 64'(16'h00FF));

        chk("wr_q_empty", 64'(wr_q.size()), 64'(0));
        chk("rd_q_empty", 64'(rd_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
